pe_result_collector: RTL and testbench
======================================

Name: pe_result_collector

Overview:
- Receive-side counterpart of the skewed operand feeder for pe_8x8_cluster.
- Watches the cluster's per-PE done flags and latches each PE's accumulated result as its flag rises.
- Once all PEs have reported, streams the 64 results out one per beat, in PE index order, over a valid/ready interface.
- Sits between the cluster outputs (results, output_dones) and the downstream writer (softmax/scale stage or memory writer).

Parameters:
- ROWS, 8, PE rows in the cluster.
- COLS, 8, PE columns in the cluster.
- RES_W, 36, bits per PE result; results bus is ROWS*COLS*RES_W wide (2304 at defaults).
- IDX_W, 6, output index width; must equal clog2(ROWS*COLS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; when low, all state and registers hold.
- results  input  ROWS*COLS*RES_W  cluster result bus; PE k occupies [k*RES_W +: RES_W], k = row*COLS+col.
- pe_dones  input  ROWS*COLS  cluster per-PE done flags; bit k belongs to PE k.
- out_data  output  RES_W  result being presented.
- out_idx  output  IDX_W  PE index of out_data.
- out_valid  output  1  out_data/out_idx are valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high with the beat where out_idx = ROWS*COLS-1.
- frame_done  output  1  one-cycle pulse after the last beat is accepted.
- busy  output  1  high while in DRAIN.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - out_valid, out_last, frame_done, busy, err, out_idx and out_data (all 0);
  - captured[] vector (all 0);
  - done_q[] (previous pe_dones), all 0;
  - state goes to COLLECT.
  - The result buffer is not reset.
- en=0: no register changes, including done_q. Outputs hold. No transfer occurs even if out_valid and out_ready are both high.
- Edge detection: rise[k] = pe_dones[k] & ~done_q[k]. done_q is updated every enabled cycle.
- COLLECT state:
  - For each k with rise[k] and captured[k]=0: buf[k] <= results slice k, captured[k] <= 1, on the same edge. Multiple k may capture in the same cycle.
  - rise[k] with captured[k]=1: no capture; set err.
  - When captured is all-ones, or becomes all-ones at this edge, move to DRAIN on the next edge.
  - Latency: last capture at edge t gives out_valid=1 with out_idx=0 after edge t+1.
- DRAIN state:
  - busy=1. out_valid=1, out_data=buf[out_idx], out_last=(out_idx==ROWS*COLS-1).
  - A transfer is out_valid & out_ready & en. On transfer, out_idx increments.
  - Without a transfer, out_data, out_idx and out_valid hold stable (no withdrawal of valid).
  - Any rise[k] during DRAIN sets err and is not captured.
  - A transfer with out_last=1 moves to DONE: out_valid=0, out_idx=0, captured cleared.
- DONE state: frame_done=1 for exactly one cycle, then COLLECT.
  - A rise[k] in the DONE cycle is ignored for capture; err is not set.
  - Clearing done_q is not required, since edge detection already handles levels that stay high.
- err is cleared only by reset.
- Throughput: one result per cycle with out_ready held high; 64 beats per frame at defaults.
- Reset mid-DRAIN: outputs drop immediately (asynchronously); the frame is discarded.

Decomposition:
- Shared package pe_cluster_pkg holds:
  - ROWS, COLS, RES_W, IDX_W constants;
  - the state encoding COLLECT=2'd0, DRAIN=2'd1, DONE=2'd2;
  - the PE index formula row*COLS+col.
- One natural sub-module: pe_done_edge. It contains the per-bit done_q register and rise/error generation, parameterised by width.
- The buffer and the drain FSM stay in the top module.

Test Plan:
- Result 0x0_0000_1000+k for PE k; pe_dones bits rise one per cycle k=0..63; out_ready=1 -> 64 beats, out_idx 0..63, data 0x1000..0x103F, out_last on idx 63, frame_done pulses one cycle after, err=0.
- All 64 pe_dones rise in the same cycle with results = 36'hF_FFFF_FFFF -> first valid two edges later, all 64 beats equal 36'hF_FFFF_FFFF.
- out_ready toggling 1,0,0,1 per cycle during drain -> out_idx/out_data stable while ready=0, no skipped or duplicated index, 64 beats total.
- PE 5 done drops to 0 and re-rises before PE 63 reports -> buf[5] keeps first value, err=1 and stays 1 through frame.
- en=0 for 3 cycles mid-drain with out_ready=1 -> out_idx frozen; resumes at next index after en=1.
- rst_n=0 asserted at out_idx=20 -> out_valid=0 immediately; after release a fresh frame drains from idx 0 with new data.

Source files
------------

// File: rtl/pe_cluster_pkg.sv
// Shared constants, state encoding and PE indexing for the pe_8x8_cluster result path.
package pe_cluster_pkg;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned RES_W  = 36;
    localparam int unsigned NUM_PE = ROWS * COLS;
    localparam int unsigned IDX_W  = $clog2(NUM_PE);

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StDrain   = 2'd1,
        StDone    = 2'd2
    } state_e;

    // Flat PE index as laid out on the cluster result bus.
    function automatic int unsigned pe_index(input int unsigned row, input int unsigned col);
        return row * COLS + col;
    endfunction

endpackage

// File: rtl/pe_result_collector_if.sv
// Valid/ready result stream from the collector to the downstream writer.
interface pe_result_collector_if #(
    parameter int unsigned RES_W = pe_cluster_pkg::RES_W,
    parameter int unsigned IDX_W = pe_cluster_pkg::IDX_W
);
    logic [RES_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/pe_done_edge.sv
// Per-PE done-flag edge detector with protocol-error flagging on masked bits.
module pe_done_edge #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_dones,
    input  logic [W-1:0] i_err_mask,
    output logic [W-1:0] o_rise,
    output logic         o_err_hit
);
    logic [W-1:0] r_done_q;

    // Track the previous enabled sample of the done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q <= '0;
        end else if (i_en) begin
            r_done_q <= i_dones;
        end
    end

    // A rise on any bit the caller marks as not-expecting-one is an error.
    always_comb begin
        o_rise    = i_dones & ~r_done_q;
        o_err_hit = |(o_rise & i_err_mask);
    end
endmodule

// File: rtl/pe_result_collector.sv
// Latches each PE result on its done rise, then streams all results out in PE index order.
module pe_result_collector #(
    parameter int unsigned ROWS  = pe_cluster_pkg::ROWS,
    parameter int unsigned COLS  = pe_cluster_pkg::COLS,
    parameter int unsigned RES_W = pe_cluster_pkg::RES_W,
    parameter int unsigned IDX_W = pe_cluster_pkg::IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [ROWS*COLS*RES_W-1:0]  results,
    input  logic [ROWS*COLS-1:0]        pe_dones,
    pe_result_collector_if.master       out_if,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        err
);
    import pe_cluster_pkg::*;

    localparam int unsigned       N        = ROWS * COLS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    state_e           r_state, w_state_d;
    logic [N-1:0]     r_captured, w_captured_d;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic             r_err;
    logic [RES_W-1:0] r_buf [N];

    logic [N-1:0]     w_rise, w_err_mask, w_capture;
    logic             w_err_hit, w_xfer, w_last, w_drain;

    pe_done_edge #(
        .W (N)
    ) u_done_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_dones    (pe_dones),
        .i_err_mask (w_err_mask),
        .o_rise     (w_rise),
        .o_err_hit  (w_err_hit)
    );

    // Decide which rises capture and which count as protocol errors; DONE ignores rises.
    always_comb begin
        w_err_mask = '0;
        w_capture  = '0;
        unique case (r_state)
            StCollect: begin
                w_err_mask = r_captured;
                w_capture  = w_rise & ~r_captured;
            end
            StDrain:   w_err_mask = '1;
            default:   w_err_mask = '0;
        endcase
    end

    // Next-state logic for the collect/drain/done sequence.
    always_comb begin
        w_drain      = (r_state == StDrain);
        w_last       = w_drain && (r_idx == LAST_IDX);
        w_xfer       = w_drain && out_if.out_ready && en;
        w_state_d    = r_state;
        w_captured_d = r_captured;
        w_idx_d      = r_idx;
        unique case (r_state)
            StCollect: begin
                w_captured_d = r_captured | w_capture;
                // Registered all-ones: drain starts one edge after the final capture.
                if (&r_captured) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_d    = StDone;
                        w_idx_d      = '0;
                        w_captured_d = '0;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_d = StCollect;
        endcase
    end

    // Control state; everything freezes while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StCollect;
            r_captured <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
        end else if (en) begin
            r_state    <= w_state_d;
            r_captured <= w_captured_d;
            r_idx      <= w_idx_d;
            r_err      <= r_err | w_err_hit;
        end
    end

    // Result buffer, intentionally without reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(N); k++) begin
            if (en && w_capture[k]) begin
                r_buf[k] <= results[k*RES_W +: RES_W];
            end
        end
    end

    // Outputs decode from state so a reset drops them immediately.
    always_comb begin
        out_if.out_valid = w_drain;
        out_if.out_last  = w_last;
        out_if.out_idx   = r_idx;
        out_if.out_data  = w_drain ? r_buf[r_idx] : '0;
        busy             = w_drain;
        frame_done       = (r_state == StDone);
        err              = r_err;
    end
endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: randomized frames against a queue-based model.
`timescale 1ns/1ps
module tb_pe_result_collector;
    import pe_cluster_pkg::*;

    localparam int unsigned N = NUM_PE;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [RES_W-1:0] data;
        logic             last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [N*RES_W-1:0] results = '0;
    logic [N-1:0]       pe_dones = '0;
    logic               frame_done, busy, err;

    pe_result_collector_if u_if ();

    pe_result_collector u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .results    (results),
        .pe_dones   (pe_dones),
        .out_if     (u_if.master),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    int               n_checks = 0;
    int               n_fail = 0;
    beat_t            sb[$];
    bit               exp_err = 1'b0;
    int               ready_mode = 0;
    int               fd_state = 0;
    logic [RES_W-1:0] model_buf [N];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] rand_res();
        return RES_W'({$urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // out_ready pattern driver
    initial begin
        int cnt;
        cnt = 0;
        u_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       u_if.out_ready = 1'b1;
                1:       u_if.out_ready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
                default: u_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            cnt++;
        end
    end

    // Monitor: compares every presented beat with the scoreboard head.
    initial begin
        forever begin
            beat_t b;
            @(negedge clk);
            if (!rst_n) begin
                check("valid_in_reset", 64'(u_if.out_valid), 64'd0);
            end else begin
                if (fd_state == 1) begin
                    check("frame_done_pulse", 64'(frame_done), 64'd1);
                    fd_state = 2;
                end else if (fd_state == 2) begin
                    check("frame_done_single", 64'(frame_done), 64'd0);
                    fd_state = 0;
                end
                if (u_if.out_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: idx %0d presented, required none",
                                 u_if.out_idx);
                    end else begin
                        b = sb[0];
                        check("out_idx", 64'(u_if.out_idx), 64'(b.idx));
                        check("out_data", 64'(u_if.out_data), 64'(b.data));
                        check("out_last", 64'(u_if.out_last), 64'(b.last));
                        if (en && u_if.out_ready) begin
                            void'(sb.pop_front());
                            if (b.last) fd_state = 1;
                        end
                    end
                end
            end
        end
    end

    // order: 0 one PE per cycle, 1 all at once, 2 random order/batches
    // pat:   0 0x1000+k, 1 all ones, 2 random
    task automatic collect(input int order, input int pat, input bit inject);
        int perm[N];
        int tmp, j;
        logic [RES_W-1:0] v;
        pe_dones = '0;
        step();
        for (int k = 0; k < int'(N); k++) begin
            v = (pat == 0) ? RES_W'(36'h1000 + k) : (pat == 1) ? '1 : rand_res();
            results[k*RES_W +: RES_W] = v;
            model_buf[k] = v;
        end
        if (order == 0) begin
            for (int k = 0; k < int'(N); k++) begin
                pe_dones[k] = 1'b1;
                step();
                if (inject && k == 40) begin
                    tmp = int'(pe_index(0, 5));
                    pe_dones[tmp] = 1'b0;
                    results[tmp*RES_W +: RES_W] = ~model_buf[tmp];
                    step();
                    pe_dones[tmp] = 1'b1;
                    step();
                    exp_err = 1'b1;
                end
            end
        end else if (order == 1) begin
            pe_dones = '1;
        end else begin
            for (int k = 0; k < int'(N); k++) perm[k] = k;
            for (int k = int'(N) - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                tmp = perm[k];
                perm[k] = perm[j];
                perm[j] = tmp;
            end
            for (int k = 0; k < int'(N); k++) begin
                pe_dones[perm[k]] = 1'b1;
                if ($urandom_range(0, 1) == 1) step();
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            sb.push_back('{idx: IDX_W'(k), data: model_buf[k], last: (k == int'(N) - 1)});
        end
        if (order == 1) begin
            @(posedge clk);
            @(negedge clk);
            check("latency_not_yet_valid", 64'(u_if.out_valid), 64'd0);
            @(negedge clk);
            check("latency_first_valid", 64'(u_if.out_valid), 64'd1);
            check("latency_first_idx", 64'(u_if.out_idx), 64'd0);
        end
        step();
        // Results bus changes after capture must not reach the buffer.
        for (int k = 0; k < int'(N); k++) results[k*RES_W +: RES_W] = rand_res();
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 3000) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d beats left, required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
        #2;
        check({name, "_err"}, 64'(err), 64'(exp_err));
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_sb_below(input int level);
        int c;
        c = 0;
        while (sb.size() > level && c < 3000) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (sb.size() > level) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_progress: %0d beats left, required <= %0d", sb.size(), level);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(u_if.out_valid), 64'd0);
        check("rst_last", 64'(u_if.out_last), 64'd0);
        check("rst_idx", 64'(u_if.out_idx), 64'd0);
        check("rst_data", 64'(u_if.out_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        step();

        // Sequential reports, incrementing data, ready always high.
        ready_mode = 0;
        collect(0, 0, 1'b0);
        wait_drain("seq_frame");

        // All PEs at once, all-ones data.
        collect(1, 1, 1'b0);
        wait_drain("burst_frame");

        // Random order, ready toggling 1,0,0,1.
        ready_mode = 1;
        collect(2, 2, 1'b0);
        wait_drain("toggle_frame");

        // PE 5 re-rises before PE 63 reports; random ready.
        ready_mode = 2;
        collect(0, 2, 1'b1);
        wait_drain("reraise_frame");

        // Enable dropped for three cycles mid-drain; err stays sticky.
        ready_mode = 0;
        collect(2, 2, 1'b0);
        wait_sb_below(40);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("en_low_valid_held", 64'(u_if.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_drain("en_frame");

        // Reset at out_idx 20 discards the frame and clears err.
        collect(2, 2, 1'b0);
        c = 0;
        while (!(u_if.out_valid && u_if.out_idx == IDX_W'(20)) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("reached_idx20", 64'(u_if.out_idx), 64'd20);
        #1;
        rst_n = 1'b0;
        pe_dones = '0;
        sb.delete();
        fd_state = 0;
        exp_err = 1'b0;
        #1;
        check("midrst_valid", 64'(u_if.out_valid), 64'd0);
        check("midrst_idx", 64'(u_if.out_idx), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        collect(2, 2, 1'b0);
        wait_drain("post_reset_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
